// File: rtl/jtdd_snd_cmdfifo.sv
// jtdd_snd_cmdfifo
// Sound command FIFO. It replaces the single sound latch and the NMI flip-flop
// between the main CPU and the sound Z80. Back-to-back commands queue up while
// the Z80 is busy. The head entry is presented on the Z80 latch read path.
//
// Ports
//   clk       system clock; all logic runs on its rising edge
//   rst_n     synchronous reset, active low
//   main_wr   main-CPU latch write strobe; its rising edge pushes main_din
//   main_din  command data [DW-1:0]
//   snd_rd    sound-CPU latch select (level); its falling edge pops the head
//   snd_dout  head entry, registered; holds the last value when empty
//   nmi_n     sound-CPU NMI, active low (latched or pulsed, see NMI_MODE)
//   empty     no entries stored
//   full      2^AW entries stored
//   count     number of stored entries [AW:0]
//   ovf       sticky overflow flag, set when a push is dropped
//   ovf_clr   one-cycle pulse that clears ovf (a new overflow wins)
module jtdd_snd_cmdfifo #(
    parameter int DW       = 8,
    parameter int AW       = 3,
    parameter int NMI_MODE = 0,
    parameter int NMI_W    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          main_wr,
    input  logic [DW-1:0] main_din,
    input  logic          snd_rd,
    output logic [DW-1:0] snd_dout,
    output logic          nmi_n,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int DEPTH = 1 << AW;
    // Pointers need at least one bit. With AW=0 they are held at zero.
    localparam int PW    = (AW > 0) ? AW : 1;

    localparam logic [AW:0] CNT_ZERO = '0;
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_d;
    logic          rd_d;

    logic          push_ev;
    logic          pop_ev;
    logic          rd_rise;
    logic          push_ok;
    logic          pop_ok;
    logic [AW:0]   count_nxt;
    logic [DW-1:0] dout_nxt;

    logic          nmi_lat;
    logic [1:0]    nmi_st;
    logic [7:0]    pw_cnt;
    logic          pend;
    logic          trig;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (AW == 0)
            return '0;
        else
            return p + PW'(1);
    endfunction

    assign push_ev = main_wr & ~wr_d;
    assign pop_ev  = ~snd_rd & rd_d;
    assign rd_rise = snd_rd & ~rd_d;

    assign empty = (count == CNT_ZERO);
    assign full  = (count == CNT_FULL);

    // A pop on an empty FIFO is ignored. When full, a push is accepted only
    // if a real pop frees the slot in the same cycle.
    assign pop_ok  = pop_ev & ~empty;
    assign push_ok = push_ev & (~full | pop_ok);

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Next head value. When only one entry is left and it is popped together
    // with a push, the new head is the incoming data. Its memory slot is
    // written in this same cycle, so main_din bypasses the array.
    always_comb begin
        dout_nxt = snd_dout;
        if (pop_ok) begin
            if (count == CNT_ONE) begin
                if (push_ok)
                    dout_nxt = main_din;
            end else begin
                dout_nxt = mem[ptr_inc(rd_ptr)];
            end
        end else if (push_ok && empty) begin
            dout_nxt = main_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok)
            mem[wr_ptr] <= main_din;
    end

    always_ff @(posedge clk) begin
        // The edge detectors track the inputs even in reset. A strobe that is
        // already high when reset is released therefore creates no event.
        wr_d <= main_wr;
        rd_d <= snd_rd;
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            snd_dout <= '0;
        end else begin
            count    <= count_nxt;
            snd_dout <= dout_nxt;
            if (push_ok)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push_ev && !push_ok)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    // Latched NMI: the Z80 acknowledges an NMI by starting the latch read.
    // The NMI is asserted again if entries remain after the pop.
    always_ff @(posedge clk) begin
        if (!rst_n)
            nmi_lat <= 1'b1;
        else if (rd_rise)
            nmi_lat <= 1'b1;
        else if (push_ok || (pop_ok && count_nxt != CNT_ZERO))
            nmi_lat <= 1'b0;
    end

    // Pulsed NMI: a fixed-length low pulse. A trigger that arrives during a
    // pulse is remembered. It is serviced after a one-cycle high gap, but only
    // if entries are still stored.
    assign trig = (push_ok && empty) || (pop_ok && count_nxt != CNT_ZERO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nmi_st <= ST_IDLE;
            pw_cnt <= '0;
            pend   <= 1'b0;
        end else begin
            case (nmi_st)
                ST_IDLE: begin
                    if (trig) begin
                        nmi_st <= ST_PULSE;
                        pw_cnt <= 8'(NMI_W - 1);
                    end
                end
                ST_PULSE: begin
                    if (trig)
                        pend <= 1'b1;
                    if (pw_cnt == 8'd0)
                        nmi_st <= ST_GAP;
                    else
                        pw_cnt <= pw_cnt - 8'd1;
                end
                ST_GAP: begin
                    pend <= 1'b0;
                    if ((pend || trig) && count_nxt != CNT_ZERO) begin
                        nmi_st <= ST_PULSE;
                        pw_cnt <= 8'(NMI_W - 1);
                    end else begin
                        nmi_st <= ST_IDLE;
                    end
                end
                default: begin
                    nmi_st <= ST_IDLE;
                    pend   <= 1'b0;
                end
            endcase
        end
    end

    assign nmi_n = (NMI_MODE == 0) ? nmi_lat : (nmi_st != ST_PULSE);

endmodule

// File: tb/tb_jtdd_snd_cmdfifo.sv
// Bench for jtdd_snd_cmdfifo. It drives two instances from the same inputs.
// dut0 uses the defaults (depth 8, latched NMI). dut1 uses the pulsed NMI
// with a 4-cycle pulse. A queue model supplies the expected data order.
module tb_jtdd_snd_cmdfifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       main_wr;
    logic [7:0] main_din;
    logic       snd_rd;
    logic       ovf_clr;

    logic [7:0] dout0, dout1;
    logic       nmi0, nmi1;
    logic       empty0, empty1;
    logic       full0, full1;
    logic [3:0] count0, count1;
    logic       ovf0, ovf1;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] exp_dout;
    logic       exp_ovf;

    int runs[$];
    int run_len = 0;

    jtdd_snd_cmdfifo #(.DW(8), .AW(3), .NMI_MODE(0), .NMI_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .main_wr(main_wr), .main_din(main_din),
        .snd_rd(snd_rd), .snd_dout(dout0), .nmi_n(nmi0), .empty(empty0),
        .full(full0), .count(count0), .ovf(ovf0), .ovf_clr(ovf_clr)
    );

    jtdd_snd_cmdfifo #(.DW(8), .AW(3), .NMI_MODE(1), .NMI_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .main_wr(main_wr), .main_din(main_din),
        .snd_rd(snd_rd), .snd_dout(dout1), .nmi_n(nmi1), .empty(empty1),
        .full(full1), .count(count1), .ovf(ovf1), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Measure the length of each low run of the pulsed NMI.
    always @(negedge clk) begin
        if (nmi1 === 1'b0)
            run_len = run_len + 1;
        else if (run_len != 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        main_wr  = 1'b1;
        main_din = d;
        tick();
        if (q.size() < 8) begin
            if (q.size() == 0)
                exp_dout = d;
            q.push_back(d);
            chk("push_nmi", nmi0, 1'b0);
        end else begin
            exp_ovf = 1'b1;
        end
        chk("push_count", count0, q.size());
        chk("push_ovf", ovf0, exp_ovf);
        chk("push_full", full0, q.size() == 8);
        chk("push_empty", empty0, q.size() == 0);
        chk("push_dout", dout0, exp_dout);
        main_wr = 1'b0;
        tick();
    endtask

    task automatic rd();
        snd_rd = 1'b1;
        tick();
        chk("rd_nmi_ack", nmi0, 1'b1);
        tick();
        tick();
        tick();
        if (q.size() > 0)
            chk("rd_data", dout0, q[0]);
        snd_rd = 1'b0;
        tick();
        if (q.size() > 0) begin
            void'(q.pop_front());
            if (q.size() > 0)
                exp_dout = q[0];
        end
        chk("pop_count", count0, q.size());
        chk("pop_empty", empty0, q.size() == 0);
        chk("pop_dout", dout0, exp_dout);
        chk("pop_nmi", nmi0, (q.size() > 0) ? 1'b0 : 1'b1);
    endtask

    initial begin
        int base;
        rst_n    = 1'b0;
        main_wr  = 1'b0;
        main_din = 8'h00;
        snd_rd   = 1'b0;
        ovf_clr  = 1'b0;
        exp_dout = 8'h00;
        exp_ovf  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_count", count0, 0);
        chk("rst_empty", empty0, 1'b1);
        chk("rst_full", full0, 1'b0);
        chk("rst_ovf", ovf0, 1'b0);
        chk("rst_nmi", nmi0, 1'b1);
        chk("rst_nmi1", nmi1, 1'b1);
        chk("rst_dout", dout0, 8'h00);

        // Single command
        push(8'h5A);
        rd();
        chk("single_hold", dout0, 8'h5A);

        // Fill and overflow
        for (int i = 1; i <= 8; i++)
            push(i[7:0]);
        chk("fill_full", full0, 1'b1);
        push(8'h09);
        chk("ovf_set", ovf0, 1'b1);
        for (int i = 0; i < 8; i++)
            rd();
        chk("ovf_sticky", ovf0, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        chk("ovf_clr", ovf0, 1'b0);

        // Wrap-around
        for (int i = 0; i < 20; i++) begin
            push(8'(i + 8'h40));
            rd();
        end
        chk("wrap_ovf", ovf0, 1'b0);

        // Simultaneous push and pop when full
        for (int i = 0; i < 8; i++)
            push(8'(8'h10 + i));
        snd_rd = 1'b1;
        tick();
        chk("sim_nmi_ack", nmi0, 1'b1);
        tick();
        tick();
        chk("sim_head", dout0, q[0]);
        snd_rd   = 1'b0;
        main_wr  = 1'b1;
        main_din = 8'hAA;
        tick();
        void'(q.pop_front());
        q.push_back(8'hAA);
        exp_dout = q[0];
        chk("sim_count", count0, 8);
        chk("sim_full", full0, 1'b1);
        chk("sim_ovf", ovf0, 1'b0);
        chk("sim_dout", dout0, exp_dout);
        chk("sim_nmi", nmi0, 1'b0);
        main_wr = 1'b0;
        tick();
        for (int i = 0; i < 8; i++)
            rd();
        chk("sim_tail_empty", empty0, 1'b1);
        chk("sim_tail_dout", dout0, 8'hAA);

        // Pulsed NMI
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        q.delete();
        exp_dout = 8'h00;
        exp_ovf  = 1'b0;
        base = runs.size();
        push(8'hC1);
        chk("pulse_start", nmi1, 1'b0);
        push(8'hC2);
        push(8'hC3);
        chk("pulse_count1", count1, 3);
        for (int i = 0; i < 4; i++)
            tick();
        for (int k = 0; k < 3; k++) begin
            rd();
            for (int i = 0; i < 6; i++)
                tick();
        end
        for (int i = 0; i < 4; i++)
            tick();
        chk("pulse_num", runs.size() - base, 3);
        for (int k = 0; k < 3; k++)
            if (base + k < runs.size())
                chk("pulse_len", runs[base + k], 4);
        chk("pulse_idle", nmi1, 1'b1);

        // Reset mid-operation, with ovf set and the write strobe held high
        for (int i = 0; i < 9; i++)
            push(8'(8'h60 + i));
        for (int i = 0; i < 5; i++)
            rd();
        chk("mid_count", count0, 3);
        chk("mid_nmi", nmi0, 1'b0);
        chk("mid_ovf", ovf0, 1'b1);
        main_wr  = 1'b1;
        main_din = 8'h77;
        rst_n    = 1'b0;
        tick();
        q.delete();
        exp_dout = 8'h00;
        exp_ovf  = 1'b0;
        chk("mrst_count", count0, 0);
        chk("mrst_empty", empty0, 1'b1);
        chk("mrst_full", full0, 1'b0);
        chk("mrst_nmi", nmi0, 1'b1);
        chk("mrst_dout", dout0, 8'h00);
        chk("mrst_ovf", ovf0, 1'b0);
        chk("mrst_count1", count1, 0);
        chk("mrst_empty1", empty1, 1'b1);
        chk("mrst_full1", full1, 1'b0);
        chk("mrst_nmi1", nmi1, 1'b1);
        chk("mrst_dout1", dout1, 8'h00);
        chk("mrst_ovf1", ovf1, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("held_wr_count", count0, 0);
        chk("held_wr_empty", empty0, 1'b1);
        main_wr = 1'b0;
        tick();
        push(8'h33);
        chk("post_rst_dout", dout0, 8'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
